// File: rtl/pong_score_pkg.sv
// ---------------------------------------------------------------------------
// pong_score_pkg
// Shared definitions for the Pong score sequencer: the controller state
// encoding, player identifiers, score width and a saturating score helper.
// No ports (package).
// ---------------------------------------------------------------------------
package pong_score_pkg;

   localparam int SCORE_W = 3;

   localparam logic PLAYER_1 = 1'b0;
   localparam logic PLAYER_2 = 1'b1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SHOW_P1   = 3'd1,
      SHOW_P2   = 3'd2,
      FLASH     = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   // One goal's worth of increment, pinned at the winning score.
   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] score,
                                                    input logic [SCORE_W-1:0] limit);
      return (score >= limit) ? limit : score + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/pong_score_sequencer_blink_timer.sv
// ---------------------------------------------------------------------------
// blink_timer
// Free-running blank-phase generator shared by the goal flash and the
// game-over blink. While enabled it counts FLASH_CYCLES clocks per phase and
// flips the phase at the end of each period. restart forces a fresh period
// with phase 0 (display visible).
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   enable   in   count while high
//   restart  in   begin a new period with phase 0 (wins over enable)
//   toggle   out  high in the cycle whose closing edge flips the phase
//   phase    out  current blank phase (1 = blanked)
// ---------------------------------------------------------------------------
module blink_timer #(
   parameter int FLASH_CYCLES = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic restart,
   output logic toggle,
   output logic phase
);

   localparam int            CW   = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(FLASH_CYCLES - 1);

   logic [CW-1:0] cnt_reg;
   logic          phase_reg;

   assign toggle = enable && !restart && (cnt_reg == LAST);
   assign phase  = phase_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg   <= '0;
         phase_reg <= 1'b0;
      end else if (restart) begin
         cnt_reg   <= '0;
         phase_reg <= 1'b0;
      end else if (enable) begin
         if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            phase_reg <= ~phase_reg;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

endmodule

// File: rtl/pong_score_sequencer.sv
// ---------------------------------------------------------------------------
// pong_score_sequencer
// Feeds the 8x8 dot-matrix character stage: keeps both players' scores,
// alternates which score is shown, flashes the scorer's digit after a goal
// and latches a blinking game-over display once a player hits WIN_SCORE.
//
// Build option: define GOAL_FLASH_EN to include the post-goal FLASH state.
// Without it a goal only updates the score; the SHOW alternation carries on
// untouched. The game-over blink is present in both builds.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   start       in   one-cycle pulse, begins/restarts a match
//   goal_p1     in   one-cycle pulse, player 1 scored
//   goal_p2     in   one-cycle pulse, player 2 scored
//   digit       out  score value for the character stage (3 bits)
//   player_sel  out  0 = player 1 shown, 1 = player 2 shown
//   blank       out  1 = downstream gates the columns off
//   game_over   out  high while the match is over
//   winner      out  winning player, meaningful while game_over = 1
//
// All outputs are registered; they are computed from the next-state values,
// so they reflect a sampled input one clock after it is seen.
// ---------------------------------------------------------------------------
module pong_score_sequencer
   import pong_score_pkg::*;
#(
   parameter int DWELL_CYCLES  = 25_000_000,
   parameter int FLASH_CYCLES  = 5_000_000,
   parameter int FLASH_TOGGLES = 6,
   parameter int WIN_SCORE     = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               goal_p1,
   input  logic               goal_p2,
   output logic [SCORE_W-1:0] digit,
   output logic               player_sel,
   output logic               blank,
   output logic               game_over,
   output logic               winner
);

   localparam int                 DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DW-1:0]      DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

   // Elaboration-time guard on the parameter ranges the controller relies on.
   if (WIN_SCORE < 1 || WIN_SCORE > 7) begin : g_bad_win
      $error("WIN_SCORE must be within 1..7");
   end
   if (FLASH_TOGGLES < 2 || (FLASH_TOGGLES % 2) != 0) begin : g_bad_toggles
      $error("FLASH_TOGGLES must be even and at least 2");
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t             state_reg, state_next;
   logic [SCORE_W-1:0] score_reg [2];
   logic [SCORE_W-1:0] score_next [2];
   logic [DW-1:0]      dwell_reg, dwell_next;
   logic               winner_reg, winner_next;

`ifdef GOAL_FLASH_EN
   localparam int            TW          = $clog2(FLASH_TOGGLES + 1);
   localparam logic [TW-1:0] TOGGLE_LAST = TW'(FLASH_TOGGLES - 1);

   logic          flash_player_reg, flash_player_next;
   logic [TW-1:0] toggle_reg, toggle_next;
`endif

   logic               digit_reg, unused_placeholder;
   logic [SCORE_W-1:0] digit_out_reg, digit_next;
   logic               sel_reg, sel_next;
   logic               blank_reg, blank_next;
   logic               game_over_reg, game_over_next;

   logic               goal_live;
   logic               blink_enable, blink_restart, blink_toggle, blink_phase, blink_phase_next;

   assign digit_reg          = 1'b0;
   assign unused_placeholder = digit_reg;

   // ------------------------------------------------------------------
   // Per-player goal evaluation
   // ------------------------------------------------------------------
   logic [1:0]         goal;
   logic [SCORE_W-1:0] score_bump [2];
   logic [1:0]         reached;

   assign goal = {goal_p2, goal_p1};

   for (genvar gi = 0; gi < 2; gi++) begin : g_player
      assign score_bump[gi] = goal[gi] ? score_inc(score_reg[gi], WIN) : score_reg[gi];
      assign reached[gi]    = goal[gi] && (score_bump[gi] == WIN);
   end

   // ------------------------------------------------------------------
   // Blank-phase timer shared by FLASH and GAME_OVER
   // ------------------------------------------------------------------
`ifdef GOAL_FLASH_EN
   assign blink_enable = (state_reg == FLASH) || (state_reg == GAME_OVER);
`else
   assign blink_enable = (state_reg == GAME_OVER);
`endif

   blink_timer #(
      .FLASH_CYCLES (FLASH_CYCLES)
   ) u_blink (
      .clk     (clk),
      .rst     (rst),
      .enable  (blink_enable),
      .restart (blink_restart),
      .toggle  (blink_toggle),
      .phase   (blink_phase)
   );

   // Phase the timer will hold after this edge; mirrored into blank_reg.
   assign blink_phase_next = blink_restart ? 1'b0 : (blink_phase ^ blink_toggle);

   // ------------------------------------------------------------------
   // Next-state logic. Priority, lowest to highest:
   //   timer-driven transitions < goals < start
   // ------------------------------------------------------------------
   always_comb begin
      state_next    = state_reg;
      score_next    = score_reg;
      dwell_next    = dwell_reg;
      winner_next   = winner_reg;
      blink_restart = 1'b0;
`ifdef GOAL_FLASH_EN
      flash_player_next = flash_player_reg;
      toggle_next       = toggle_reg;
      goal_live = (state_reg == SHOW_P1) || (state_reg == SHOW_P2) || (state_reg == FLASH);
`else
      goal_live = (state_reg == SHOW_P1) || (state_reg == SHOW_P2);
`endif

      case (state_reg)
         IDLE, GAME_OVER: ;
         SHOW_P1, SHOW_P2: begin
            if (dwell_reg == DWELL_LAST) begin
               dwell_next = '0;
               state_next = (state_reg == SHOW_P1) ? SHOW_P2 : SHOW_P1;
            end else begin
               dwell_next = dwell_reg + DW'(1);
            end
         end
`ifdef GOAL_FLASH_EN
         FLASH: begin
            if (blink_toggle) begin
               // Even toggle count means the last flip lands on visible.
               if (toggle_reg == TOGGLE_LAST) begin
                  state_next = (flash_player_reg == PLAYER_1) ? SHOW_P1 : SHOW_P2;
                  dwell_next = '0;
               end else begin
                  toggle_next = toggle_reg + TW'(1);
               end
            end
         end
`endif
         default: state_next = IDLE;
      endcase

      if (goal_live && (goal != 2'b00)) begin
         score_next = score_bump;
         // Player 1 is checked first so a double win goes to player 1.
         if (reached[PLAYER_1]) begin
            state_next    = GAME_OVER;
            winner_next   = PLAYER_1;
            blink_restart = 1'b1;
         end else if (reached[PLAYER_2]) begin
            state_next    = GAME_OVER;
            winner_next   = PLAYER_2;
            blink_restart = 1'b1;
         end
`ifdef GOAL_FLASH_EN
         else begin
            state_next        = FLASH;
            flash_player_next = goal[PLAYER_1] ? PLAYER_1 : PLAYER_2;
            toggle_next       = '0;
            blink_restart     = 1'b1;
         end
`endif
      end

      if (start) begin
         state_next    = SHOW_P1;
         score_next[0] = '0;
         score_next[1] = '0;
         dwell_next    = '0;
         winner_next   = PLAYER_1;
         blink_restart = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Output decode from the next-state values
   // ------------------------------------------------------------------
   always_comb begin
      digit_next     = '0;
      sel_next       = PLAYER_1;
      blank_next     = 1'b1;
      game_over_next = 1'b0;
      case (state_next)
         SHOW_P1: begin
            digit_next = score_next[PLAYER_1];
            sel_next   = PLAYER_1;
            blank_next = 1'b0;
         end
         SHOW_P2: begin
            digit_next = score_next[PLAYER_2];
            sel_next   = PLAYER_2;
            blank_next = 1'b0;
         end
`ifdef GOAL_FLASH_EN
         FLASH: begin
            digit_next = score_next[flash_player_next];
            sel_next   = flash_player_next;
            blank_next = blink_phase_next;
         end
`endif
         GAME_OVER: begin
            digit_next     = score_next[winner_next];
            sel_next       = winner_next;
            blank_next     = blink_phase_next;
            game_over_next = 1'b1;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         score_reg[0]  <= '0;
         score_reg[1]  <= '0;
         dwell_reg     <= '0;
         winner_reg    <= PLAYER_1;
         digit_out_reg <= '0;
         sel_reg       <= PLAYER_1;
         blank_reg     <= 1'b1;
         game_over_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         score_reg     <= score_next;
         dwell_reg     <= dwell_next;
         winner_reg    <= winner_next;
         digit_out_reg <= digit_next;
         sel_reg       <= sel_next;
         blank_reg     <= blank_next;
         game_over_reg <= game_over_next;
      end
   end

`ifdef GOAL_FLASH_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flash_player_reg <= PLAYER_1;
         toggle_reg       <= '0;
      end else begin
         flash_player_reg <= flash_player_next;
         toggle_reg       <= toggle_next;
      end
   end
`endif

   assign digit      = digit_out_reg;
   assign player_sel = sel_reg;
   assign blank      = blank_reg;
   assign game_over  = game_over_reg;
   assign winner     = winner_reg;

endmodule

// File: tb/tb_pong_score_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pong_score_sequencer
// Directed stimulus for pong_score_sequencer with a timeline-based reference
// model (phases are tracked by their start edge; what is shown is derived
// from elapsed clocks) plus literal expectations at key points. Works in
// both the default build and with GOAL_FLASH_EN defined.
// ---------------------------------------------------------------------------
module tb_pong_score_sequencer;

   localparam int D = 4;   // DWELL_CYCLES
   localparam int F = 2;   // FLASH_CYCLES
   localparam int T = 4;   // FLASH_TOGGLES
   localparam int W = 3;   // WIN_SCORE

`ifdef GOAL_FLASH_EN
   localparam bit FLASH_EN = 1'b1;
`else
   localparam bit FLASH_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start, goal_p1, goal_p2;
   logic [2:0] digit;
   logic       player_sel, blank, game_over, winner;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   pong_score_sequencer #(
      .DWELL_CYCLES  (D),
      .FLASH_CYCLES  (F),
      .FLASH_TOGGLES (T),
      .WIN_SCORE     (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .goal_p1    (goal_p1),
      .goal_p2    (goal_p2),
      .digit      (digit),
      .player_sel (player_sel),
      .blank      (blank),
      .game_over  (game_over),
      .winner     (winner)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model: mode 0 idle, 1 showing, 2 flashing, 3 game over.
   // ------------------------------------------------------------------
   int m_mode = 0;
   int m_score [2] = '{0, 0};
   int m_t0   = 0;   // edge index at which the current phase began
   int m_base = 0;   // player shown first in a showing phase
   int m_fp   = 0;   // flashing player
   int m_win  = 0;
   int now    = 0;   // edge counter

   function automatic int sat_inc(input int s);
      return (s + 1 > W) ? W : s + 1;
   endfunction

   task automatic model_edge(input logic s, input logic g1, input logic g2);
      int n1, n2;
      if (m_mode == 2 && (now - m_t0) == F * T) begin
         m_mode = 1; m_base = m_fp; m_t0 = now;
      end
      if (s) begin
         m_mode = 1; m_score[0] = 0; m_score[1] = 0; m_base = 0; m_t0 = now; m_win = 0;
      end else if ((m_mode == 1 || m_mode == 2) && (g1 || g2)) begin
         n1 = g1 ? sat_inc(m_score[0]) : m_score[0];
         n2 = g2 ? sat_inc(m_score[1]) : m_score[1];
         m_score[0] = n1; m_score[1] = n2;
         if (g1 && n1 == W) begin
            m_mode = 3; m_win = 0; m_t0 = now;
         end else if (g2 && n2 == W) begin
            m_mode = 3; m_win = 1; m_t0 = now;
         end else if (FLASH_EN) begin
            m_mode = 2; m_fp = g1 ? 0 : 1; m_t0 = now;
         end
      end
   endtask

   task automatic model_outputs(output int d, output int sel, output int b,
                                output int g, output int w);
      int el;
      el = now - m_t0;
      d = 0; sel = 0; b = 1; g = 0; w = m_win;
      case (m_mode)
         1: begin sel = m_base ^ ((el / D) % 2); d = m_score[sel]; b = 0; end
         2: begin sel = m_fp; d = m_score[m_fp]; b = (el / F) % 2; end
         3: begin sel = m_win; d = m_score[m_win]; b = (el / F) % 2; g = 1; end
         default: ;
      endcase
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_mode = 0; m_score[0] = 0; m_score[1] = 0; m_win = 0;
         end else begin
            now++;
            model_edge(start, goal_p1, goal_p2);
         end
      end
   end

   // ------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      int ed, es, eb, eg, ew;
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            model_outputs(ed, es, eb, eg, ew);
            check("model_digit",      digit,      8'(ed));
            check("model_player_sel", player_sel, 8'(es));
            check("model_blank",      blank,      8'(eb));
            check("model_game_over",  game_over,  8'(eg));
            check("model_winner",     winner,     8'(ew));
         end
      end
   end

   task automatic expect_out(input string tag, input int d, input int s,
                             input int b, input int g, input int w);
      check({tag, "_digit"},      digit,      8'(d));
      check({tag, "_player_sel"}, player_sel, 8'(s));
      check({tag, "_blank"},      blank,      8'(b));
      check({tag, "_game_over"},  game_over,  8'(g));
      check({tag, "_winner"},     winner,     8'(w));
   endtask

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic pulse(input logic s, input logic g1, input logic g2);
      start = s; goal_p1 = g1; goal_p2 = g2;
      @(posedge clk); #1;
      start = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
      $display("txn start=%0b goal_p1=%0b goal_p2=%0b -> digit=%0d player_sel=%0b blank=%0b game_over=%0b winner=%0b",
               s, g1, g2, digit, player_sel, blank, game_over, winner);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      rst = 1'b0; start = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
      #1 rst = 1'b1;
      #1 cmp_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      expect_out("reset", 0, 0, 1, 0, 0);
      rst = 1'b0;
      idle(1);

      // goals before any start are ignored
      pulse(0, 1, 0);
      expect_out("idle_goal", 0, 0, 1, 0, 0);

      // 1: plain alternation
      pulse(1, 0, 0);
      expect_out("s1_start", 0, 0, 0, 0, 0);
      idle(3);  expect_out("s1_dwell_end", 0, 0, 0, 0, 0);
      idle(1);  expect_out("s1_p2",        0, 1, 0, 0, 0);
      idle(4);  expect_out("s1_p1_again",  0, 0, 0, 0, 0);

      // 2: goal_p2 while showing player 1
      pulse(0, 0, 1);
      if (FLASH_EN) expect_out("s2_flash_on",  1, 1, 0, 0, 0);
      else          expect_out("s2_no_flash",  0, 0, 0, 0, 0);
      idle(2);
      if (FLASH_EN) expect_out("s2_flash_off", 1, 1, 1, 0, 0);
      else          expect_out("s2_dwell",     0, 0, 0, 0, 0);
      idle(6);
      if (FLASH_EN) expect_out("s2_show_p2",   1, 1, 0, 0, 0);
      else          expect_out("s2_show_p1",   0, 0, 0, 0, 0);

      // 3: simultaneous goals
      pulse(1, 0, 0);
      pulse(0, 1, 1);
      expect_out("s3_both", 1, 0, 0, 0, 0);
      idle(2);
      if (FLASH_EN) expect_out("s3_flash_off", 1, 0, 1, 0, 0);
      else          expect_out("s3_steady",    1, 0, 0, 0, 0);
      idle(6);  expect_out("s3_show_p1", 1, 0, 0, 0, 0);
      idle(4);  expect_out("s3_show_p2", 1, 1, 0, 0, 0);

      // 4: player 1 wins, blink, ignored goal, restart; then player 2 wins
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      pulse(0, 1, 0);
      pulse(0, 1, 0);
      expect_out("s4_over",      3, 0, 0, 1, 0);
      idle(2);  expect_out("s4_blink_off", 3, 0, 1, 1, 0);
      idle(2);  expect_out("s4_blink_on",  3, 0, 0, 1, 0);
      pulse(0, 0, 1);
      expect_out("s4_goal_ignored", 3, 0, 0, 1, 0);
      pulse(1, 0, 0);
      expect_out("s4_restart", 0, 0, 0, 0, 0);
      pulse(0, 0, 1);
      pulse(0, 0, 1);
      pulse(0, 0, 1);
      expect_out("s4_p2_wins", 3, 1, 0, 1, 1);
      pulse(1, 0, 0);
      expect_out("s4_restart2", 0, 0, 0, 0, 0);

      // 5: start with a simultaneous goal mid-match
      pulse(0, 1, 0);
      idle(8);
      pulse(1, 1, 0);
      expect_out("s5_start_wins", 0, 0, 0, 0, 0);
      idle(2);  expect_out("s5_no_flash", 0, 0, 0, 0, 0);

      // 6: asynchronous reset mid-flash
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      idle(1);
      #2 rst = 1'b1;
      #1 expect_out("s6_async_rst", 0, 0, 1, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      pulse(0, 1, 0);
      expect_out("s6_goal1_ignored", 0, 0, 1, 0, 0);
      pulse(0, 0, 1);
      expect_out("s6_goal2_ignored", 0, 0, 1, 0, 0);
      pulse(1, 0, 0);
      expect_out("s6_start", 0, 0, 0, 0, 0);
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
